// File: rtl/thiele_ext_pkg.sv
// Shared types and constants for the external-request arbiter.
package thiele_ext_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  localparam int TMO_CNT_W = 16;

  // Wide enough for any practical DATA_W; cast down at the use site.
  localparam logic [255:0] TMO_DATA = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_i+1 upward with wrap,
// returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = int'(last_i) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      candIdx = IDX_W'(cand);
      if (!valid_o && req_i[candIdx] && mask_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
        grant_o = NUM_CH'(1) << candIdx;
      end
    end
  end

endmodule

// File: rtl/ext_req_arbiter.sv
// Multi-channel front end sharing one backend, one transaction at a time.
// Optional backend timeout is compiled in with EXT_ARB_TIMEOUT_EN.
module ext_req_arbiter
  import thiele_ext_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CH-1:0]                         ch_req,
  input  logic [NUM_CH*ADDR_W-1:0]                  ch_addr,
  output logic [NUM_CH-1:0]                         ch_ack,
  output logic [NUM_CH*DATA_W-1:0]                  ch_data,
  output logic [NUM_CH-1:0]                         ch_err,
  output logic                                      be_req,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] be_ch_id,
  output logic [ADDR_W-1:0]                         be_addr,
  input  logic                                      be_ack,
  input  logic [DATA_W-1:0]                         be_data,
  output logic                                      busy,
  output logic [TMO_CNT_W-1:0]                      timeout_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("ext_req_arbiter: NUM_CH or TIMEOUT_CYC out of legal range");
  end

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d, lastGrant_q, lastGrant_d;
  logic [NUM_CH-1:0]        grantOh_q, grantOh_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic                     dropMask_q, dropMask_d;

  logic [NUM_CH-1:0]        eligMask, arbGrant;
  logic [IDX_W-1:0]         arbIdx;
  logic                     arbValid;

`ifdef EXT_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0]     wait_q, wait_d, tmoCount_q, tmoCount_d;
  logic                     err_q, err_d;
`endif

  // The channel acknowledged last gets one IDLE cycle to drop its request.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligMask[i] = !(dropMask_q && (lastGrant_q == IDX_W'(i)));
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req_i   (ch_req),
    .mask_i  (eligMask),
    .last_i  (lastGrant_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grantOh_d   = grantOh_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dropMask_d  = 1'b0;
`ifdef EXT_ARB_TIMEOUT_EN
    wait_d      = wait_q;
    tmoCount_d  = tmoCount_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arbValid) begin
          grant_d   = arbIdx;
          grantOh_d = arbGrant;
          addr_d    = ch_addr[arbIdx*ADDR_W +: ADDR_W];
          state_d   = ISSUE;
`ifdef EXT_ARB_TIMEOUT_EN
          wait_d    = '0;
          err_d     = 1'b0;
`endif
        end
      end
      ISSUE: begin
        // A backend ack always beats a timeout expiring in the same cycle.
        if (be_ack) begin
          data_d[grant_q*DATA_W +: DATA_W] = be_data;
          state_d = RESP;
`ifdef EXT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wait_q == TMO_CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d[grant_q*DATA_W +: DATA_W] = DATA_W'(TMO_DATA);
          err_d   = 1'b1;
          state_d = RESP;
          if (tmoCount_q != '1) tmoCount_d = tmoCount_q + TMO_CNT_W'(1);
        end else begin
          wait_d  = wait_q + TMO_CNT_W'(1);
`endif
        end
      end
      RESP: begin
        lastGrant_d = grant_q;
        dropMask_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grantOh_q   <= '0;
      lastGrant_q <= IDX_W'(NUM_CH - 1);
      addr_q      <= '0;
      data_q      <= '0;
      dropMask_q  <= 1'b0;
`ifdef EXT_ARB_TIMEOUT_EN
      wait_q      <= '0;
      tmoCount_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grantOh_q   <= grantOh_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dropMask_q  <= dropMask_d;
`ifdef EXT_ARB_TIMEOUT_EN
      wait_q      <= wait_d;
      tmoCount_q  <= tmoCount_d;
      err_q       <= err_d;
`endif
    end
  end

  assign be_req   = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign be_ch_id = grant_q;
  assign be_addr  = addr_q;
  assign ch_data  = data_q;
  assign ch_ack   = (state_q == RESP) ? grantOh_q : '0;

`ifdef EXT_ARB_TIMEOUT_EN
  assign ch_err        = (state_q == RESP && err_q) ? grantOh_q : '0;
  assign timeout_count = tmoCount_q;
`else
  assign ch_err        = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_ext_req_arbiter.sv
// Directed bench for ext_req_arbiter (NUM_CH=2, TIMEOUT_CYC=8); timeout
// scenarios are selected by EXT_ARB_TIMEOUT_EN to match the DUT build.
module tb_ext_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_req;
  logic [63:0] ch_addr;
  logic [1:0]  ch_ack;
  logic [63:0] ch_data;
  logic [1:0]  ch_err;
  logic        be_req;
  logic [0:0]  be_ch_id;
  logic [31:0] be_addr;
  logic        be_ack;
  logic [31:0] be_data;
  logic        busy;
  logic [15:0] timeout_count;

  int testsRun = 0;
  int testsFailed = 0;

  ext_req_arbiter #(
    .NUM_CH      (2),
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_req        (ch_req),
    .ch_addr       (ch_addr),
    .ch_ack        (ch_ack),
    .ch_data       (ch_data),
    .ch_err        (ch_err),
    .be_req        (be_req),
    .be_ch_id      (be_ch_id),
    .be_addr       (be_addr),
    .be_ack        (be_ack),
    .be_data       (be_data),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] bdata;
    logic        xBeReq;
    logic        xId;
    logic [31:0] xAddr;
    logic        xBusy;
    logic [1:0]  xAck;
    logic [31:0] xD0;
    logic [31:0] xD1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] q, logic [31:0] a0, logic [31:0] a1,
                              logic k, logic [31:0] bd, logic xr, logic xi,
                              logic [31:0] xa, logic xb, logic [1:0] xk,
                              logic [31:0] d0, logic [31:0] d1);
    vec_t v;
    v.rst = r; v.req = q; v.a0 = a0; v.a1 = a1; v.ack = k; v.bdata = bd;
    v.xBeReq = xr; v.xId = xi; v.xAddr = xa; v.xBusy = xb; v.xAck = xk;
    v.xD0 = d0; v.xD1 = d1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    ch_req  = v.req;
    ch_addr = {v.a1, v.a0};
    be_ack  = v.ack;
    be_data = v.bdata;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issueCnt;

    rst = 1'b1; ch_req = '0; ch_addr = '0; be_ack = 1'b0; be_data = '0;

    //        rst req  a0     a1     ack bdata         beReq id addr   busy ack  d0            d1
    vecs.push_back(mk(1, 2'b00, 32'h10,  32'h20,  0, 32'h0,        0, 0, 32'h0,   0, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 32'h10,  32'h20,  0, 32'h0,        1, 0, 32'h10,  1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 32'h10,  32'h20,  0, 32'h0,        1, 0, 32'h10,  1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 32'h10,  32'h20,  0, 32'h0,        1, 0, 32'h10,  1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b01, 32'h10,  32'h20,  1, 32'hABCD1234, 0, 0, 32'h10,  1, 2'b01, 32'hABCD1234, 32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h10,  32'h20,  0, 32'h0,        0, 0, 32'h10,  0, 2'b00, 32'hABCD1234, 32'h0));
    // stray backend ack while idle
    vecs.push_back(mk(0, 2'b00, 32'h10,  32'h20,  1, 32'hDEAD,     0, 0, 32'h10,  0, 2'b00, 32'hABCD1234, 32'h0));
    vecs.push_back(mk(1, 2'b00, 32'h10,  32'h20,  0, 32'h0,        0, 0, 32'h0,   0, 2'b00, 32'h0,        32'h0));
    // both channels requesting: grants 0,1,0
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 0, 32'h0,        1, 0, 32'h100, 1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 1, 32'h1111,     0, 0, 32'h100, 1, 2'b01, 32'h1111,     32'h0));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 0, 32'h0,        0, 0, 32'h100, 0, 2'b00, 32'h1111,     32'h0));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 0, 32'h0,        1, 1, 32'h200, 1, 2'b00, 32'h1111,     32'h0));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 1, 32'h2222,     0, 1, 32'h200, 1, 2'b10, 32'h1111,     32'h2222));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 0, 32'h0,        0, 1, 32'h200, 0, 2'b00, 32'h1111,     32'h2222));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 0, 32'h0,        1, 0, 32'h100, 1, 2'b00, 32'h1111,     32'h2222));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h200, 1, 32'h3333,     0, 0, 32'h100, 1, 2'b01, 32'h3333,     32'h2222));
    // just-acked channel is ignored for one idle cycle
    vecs.push_back(mk(0, 2'b01, 32'h100, 32'h200, 0, 32'h0,        0, 0, 32'h100, 0, 2'b00, 32'h3333,     32'h2222));
    vecs.push_back(mk(0, 2'b01, 32'h100, 32'h200, 0, 32'h0,        0, 0, 32'h100, 0, 2'b00, 32'h3333,     32'h2222));
    vecs.push_back(mk(0, 2'b01, 32'h100, 32'h200, 0, 32'h0,        1, 0, 32'h100, 1, 2'b00, 32'h3333,     32'h2222));
    // request dropped mid-transaction still completes
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h200, 0, 32'h0,        1, 0, 32'h100, 1, 2'b00, 32'h3333,     32'h2222));
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h200, 1, 32'h4444,     0, 0, 32'h100, 1, 2'b01, 32'h4444,     32'h2222));
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h200, 0, 32'h0,        0, 0, 32'h100, 0, 2'b00, 32'h4444,     32'h2222));
    // reset during ISSUE, then channel 0 wins first
    vecs.push_back(mk(0, 2'b10, 32'h100, 32'h300, 0, 32'h0,        1, 1, 32'h300, 1, 2'b00, 32'h4444,     32'h2222));
    vecs.push_back(mk(1, 2'b11, 32'h100, 32'h300, 0, 32'h0,        0, 0, 32'h0,   0, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b11, 32'h100, 32'h300, 1, 32'h9999,     1, 0, 32'h100, 1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h300, 0, 32'h0,        1, 0, 32'h100, 1, 2'b00, 32'h0,        32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h300, 1, 32'h5555,     0, 0, 32'h100, 1, 2'b01, 32'h5555,     32'h0));
    vecs.push_back(mk(0, 2'b00, 32'h100, 32'h300, 0, 32'h0,        0, 0, 32'h100, 0, 2'b00, 32'h5555,     32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput("be_req",   i, 64'(be_req),        64'(vecs[i].xBeReq));
      checkOutput("be_ch_id", i, 64'(be_ch_id),      64'(vecs[i].xId));
      checkOutput("be_addr",  i, 64'(be_addr),       64'(vecs[i].xAddr));
      checkOutput("busy",     i, 64'(busy),          64'(vecs[i].xBusy));
      checkOutput("ch_ack",   i, 64'(ch_ack),        64'(vecs[i].xAck));
      checkOutput("ch_err",   i, 64'(ch_err),        64'(0));
      checkOutput("ch_data0", i, 64'(ch_data[31:0]),  64'(vecs[i].xD0));
      checkOutput("ch_data1", i, 64'(ch_data[63:32]), 64'(vecs[i].xD1));
      checkOutput("timeout_count", i, 64'(timeout_count), 64'(0));
    end

    // Long-wait scenario on channel 1.
    ch_req = 2'b10; ch_addr = {32'h400, 32'h100}; be_ack = 1'b0;
    tick();
    checkOutput("long_issue_id",   100, 64'(be_ch_id), 64'(1));
    checkOutput("long_issue_addr", 100, 64'(be_addr),  64'(32'h400));
    ch_req = 2'b00;
    issueCnt = 0;

`ifdef EXT_ARB_TIMEOUT_EN
    while (be_req && issueCnt < 20) begin
      issueCnt++;
      tick();
    end
    checkOutput("tmo_issue_cycles", 101, 64'(issueCnt), 64'(8));
    checkOutput("tmo_ack",   102, 64'(ch_ack),         64'(2'b10));
    checkOutput("tmo_err",   103, 64'(ch_err),         64'(2'b10));
    checkOutput("tmo_data1", 104, 64'(ch_data[63:32]), 64'(32'hFFFFFFFF));
    checkOutput("tmo_count", 105, 64'(timeout_count),  64'(1));
    tick();
    checkOutput("tmo_ack_pulse", 106, 64'(ch_ack), 64'(0));

    // be_ack on the final allowed cycle beats the timeout.
    ch_req = 2'b01;
    tick();
    checkOutput("race_issue", 107, 64'(be_req), 64'(1));
    ch_req = 2'b00;
    repeat (7) tick();
    checkOutput("race_still_issue", 108, 64'(be_req), 64'(1));
    be_ack = 1'b1; be_data = 32'h12345678;
    tick();
    be_ack = 1'b0;
    checkOutput("race_ack",   109, 64'(ch_ack),        64'(2'b01));
    checkOutput("race_err",   110, 64'(ch_err),        64'(0));
    checkOutput("race_data0", 111, 64'(ch_data[31:0]), 64'(32'h12345678));
    checkOutput("race_count", 112, 64'(timeout_count), 64'(1));
    tick();
`else
    while (be_req && issueCnt < 200) begin
      issueCnt++;
      tick();
    end
    checkOutput("wait_issue_cycles", 101, 64'(issueCnt), 64'(200));
    checkOutput("wait_still_busy",   102, 64'(busy),     64'(1));
    checkOutput("wait_no_ack",       103, 64'(ch_ack),   64'(0));
    be_ack = 1'b1; be_data = 32'h0BADF00D;
    tick();
    be_ack = 1'b0;
    checkOutput("wait_ack",   104, 64'(ch_ack),          64'(2'b10));
    checkOutput("wait_err",   105, 64'(ch_err),          64'(0));
    checkOutput("wait_data1", 106, 64'(ch_data[63:32]),  64'(32'h0BADF00D));
    checkOutput("wait_count", 107, 64'(timeout_count),   64'(0));
    tick();
    checkOutput("wait_ack_pulse", 108, 64'(ch_ack), 64'(0));
    checkOutput("wait_idle",      109, 64'(busy),   64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ext_req_arbiter.md
EXT_REQ_ARBITER -- requirements
Module: ext_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter DATA_W, default 32, response data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, backend wait limit in cycles (legal 1..65535).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port ch_req  input  NUM_CH  per-channel request level.
REQ-009 SHALL have port ch_addr  input  NUM_CH*ADDR_W  per-channel address (channel i at slice i).
REQ-010 SHALL have port ch_ack  output  NUM_CH  per-channel one-cycle completion pulse.
REQ-011 SHALL have port ch_data  output  NUM_CH*DATA_W  per-channel response data.
REQ-012 SHALL have port ch_err  output  NUM_CH  per-channel error flag, valid with ch_ack.
REQ-013 SHALL have port be_req  output  1  backend request level.
REQ-014 SHALL have port be_ch_id  output  clog2(NUM_CH) (min 1)  granted channel index.
REQ-015 SHALL have port be_addr  output  ADDR_W  latched address of granted channel.
REQ-016 SHALL have port be_ack  input  1  backend completion strobe.
REQ-017 SHALL have port be_data  input  DATA_W  backend result, valid with be_ack.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port timeout_count  output  16  saturating count of timed-out transactions.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, RESP; at most one backend transaction outstanding.
REQ-021 IDLE: if any eligible ch_req is high, grant via round-robin starting at (last_grant+1) mod NUM_CH, latch channel id and address, go to ISSUE next cycle.
REQ-022 ISSUE: be_req=1, be_ch_id/be_addr stable; be_ack sampled high -> latch be_data, ch_err=0, go to RESP.
REQ-023 RESP: ch_ack[grant]=1 for exactly one cycle, ch_data slice[grant] = latched data, ch_err[grant] as latched; next state IDLE; last_grant <= grant.
REQ-024 The channel just acknowledged SHALL be ineligible in the first IDLE cycle after RESP (requester drop-time).
REQ-025 Latency: ch_req high in IDLE at cycle t -> be_req high at t+1; be_ack sampled at cycle k -> ch_ack high at k+1.
REQ-026 ch_data slices SHALL hold last written value until overwritten; ch_ack/ch_err of non-granted channels SHALL be 0.
REQ-027 ch_req deasserting during ISSUE SHALL NOT abort; transaction completes and is acknowledged.
REQ-028 be_ack while not in ISSUE SHALL be ignored.
REQ-029 Timeout (when compiled in): wait counter clears on entry to ISSUE; if TIMEOUT_CYC cycles pass in ISSUE without be_ack, go to RESP with data all-ones and ch_err[grant]=1, timeout_count += 1 saturating at 16'hFFFF.
REQ-030 be_ack arriving in the same cycle the counter reaches TIMEOUT_CYC SHALL win (normal completion, no error).
REQ-031 NUM_CH=1 SHALL degenerate to a pass-through with be_ch_id=0.

Reset
REQ-032 rst high at a clock edge SHALL force IDLE, last_grant=NUM_CH-1 (channel 0 first), all outputs 0 (ch_data, timeout_count included), on the following cycle, regardless of any in-flight transaction.
REQ-033 A transaction interrupted by reset SHALL NOT produce ch_ack.

Configuration
REQ-034 Macro EXT_ARB_TIMEOUT_EN: defined -> REQ-029/030 active; undefined -> ISSUE waits indefinitely, ch_err and timeout_count tied to 0, no wait counter instantiated.

Structure
REQ-035 Package thiele_ext_pkg SHALL hold the FSM state enum, the timeout data constant (all-ones), and the timeout counter width constant.
REQ-036 Sub-module rr_arbiter (NUM_CH-bit request/mask in, one-hot grant plus index out, pure combinational priority rotate) SHALL implement the grant selection.

Verification
REQ-037 NUM_CH=2, ch_req=2'b01, addr0=0x10, be_ack 3 cycles after be_req with be_data=0xABCD1234 -> be_addr=0x10, ch_ack[0] pulse 1 cycle, ch_data0=0xABCD1234, ch_err=0.
REQ-038 ch_req=2'b11 held through three transactions -> grant order 0,1,0; be_ch_id sequence 0,1,0.
REQ-039 With timeout enabled, TIMEOUT_CYC=8, be_ack never asserted -> ch_ack[grant] after 8 ISSUE cycles, ch_data=0xFFFFFFFF, ch_err=1, timeout_count=1.
REQ-040 be_ack coincident with timeout expiry, be_data=0x12345678 -> ch_err=0, ch_data=0x12345678, timeout_count unchanged.
REQ-041 rst asserted in ISSUE -> next cycle be_req=0, busy=0, no ch_ack; after release, channel 0 granted first.
REQ-042 Macro undefined, be_ack delayed 200 cycles -> no timeout, ch_ack 1 cycle after be_ack, ch_err=0.
